// File: rtl/regfile_dump_reader.sv
// Sequential read-out engine: walks a contiguous register-file range through one
// asynchronous read port and streams each word out over a valid/ready handshake.
module regfile_dump_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] first_reg,
   input  logic [ADDR_WIDTH-1:0] last_reg,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH-1:0] out_index,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done,
   output logic                  range_err
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic [ADDR_WIDTH-1:0] last_q, last_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic [ADDR_WIDTH-1:0] out_index_q, out_index_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  pending_q, pending_d;
   logic                  out_valid_q, out_valid_d;
   logic                  out_last_q, out_last_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  range_err_q, range_err_d;

   logic load_s;
   logic xfer_s;
   logic at_last_s;

   assign at_last_s = (idx_q == last_q);
   // The output register refills whenever it is empty or draining this cycle.
   assign load_s    = pending_q && (!out_valid_q || out_ready);
   assign xfer_s    = out_valid_q && out_ready;

   // Next-state and next-output computation.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      last_d      = last_q;
      out_index_d = out_index_q;
      out_data_d  = out_data_q;
      pending_d   = pending_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      range_err_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (first_reg <= last_reg) begin
                  idx_d     = first_reg;
                  last_d    = last_reg;
                  pending_d = 1'b1;
                  busy_d    = 1'b1;
                  state_d   = ST_RUN;
               end else begin
                  range_err_d = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_RUN: begin
            if (abort) begin
               out_valid_d = 1'b0;
               pending_d   = 1'b0;
               busy_d      = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               if (load_s) begin
                  out_data_d  = rd_data;
                  out_index_d = idx_q;
                  out_last_d  = at_last_s;
                  out_valid_d = 1'b1;
                  // idx parks on last_q so a range ending at the top index never wraps.
                  if (at_last_s) begin
                     pending_d = 1'b0;
                  end else begin
                     idx_d = idx_q + ADDR_WIDTH'(1);
                  end
               end else if (xfer_s) begin
                  out_valid_d = 1'b0;
               end else begin
                  out_valid_d = out_valid_q;
               end

               if (xfer_s && out_last_q) begin
                  out_valid_d = 1'b0;
                  busy_d      = 1'b0;
                  done_d      = 1'b1;
                  state_d     = ST_IDLE;
               end else begin
                  busy_d = busy_q;
               end
            end
         end

         default: begin
            out_valid_d = 1'b0;
            pending_d   = 1'b0;
            busy_d      = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase

      // Registered read address tracks the index that will be live next cycle.
      if (state_d == ST_RUN) begin
         rd_addr_d = idx_d;
      end else begin
         rd_addr_d = {ADDR_WIDTH{1'b0}};
      end
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         idx_q       <= {ADDR_WIDTH{1'b0}};
         last_q      <= {ADDR_WIDTH{1'b0}};
         rd_addr_q   <= {ADDR_WIDTH{1'b0}};
         out_index_q <= {ADDR_WIDTH{1'b0}};
         out_data_q  <= {DATA_WIDTH{1'b0}};
         pending_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         range_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         last_q      <= last_d;
         rd_addr_q   <= rd_addr_d;
         out_index_q <= out_index_d;
         out_data_q  <= out_data_d;
         pending_q   <= pending_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         range_err_q <= range_err_d;
      end
   end

   assign rd_addr   = rd_addr_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_index = out_index_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign range_err = range_err_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: a register-file array model feeds the
// read port, and each dump is checked against a queue of expected words.
module tb_regfile_dump_reader;
   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          abort;
   logic [AW-1:0] first_reg;
   logic [AW-1:0] last_reg;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [AW-1:0] out_index;
   logic          out_last;
   logic          busy;
   logic          done;
   logic          range_err;

   logic [DW-1:0] regs [32];
   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   assign rd_data = regs[rd_addr];

   regfile_dump_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .first_reg(first_reg), .last_reg(last_reg), .rd_addr(rd_addr), .rd_data(rd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_index(out_index), .out_last(out_last), .busy(busy), .done(done),
      .range_err(range_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // mode 0: ready held high, 1: ready pattern 1,0,0 repeating, 2: random ready
   task automatic run_dump(input int first, input int last, input int mode, input bit abort_at_start);
      logic [31:0] exp_data[$];
      int          exp_idx[$];
      int          n;
      int          iters;
      int          done_seen;
      bit          stalled;
      logic [31:0] hold_data;
      logic [AW-1:0] hold_idx;
      logic        hold_last;
      n         = last - first + 1;
      iters     = 0;
      done_seen = 0;
      for (int r = first; r <= last; r++) begin
         exp_data.push_back(regs[r]);
         exp_idx.push_back(r);
      end
      start     = 1'b1;
      abort     = abort_at_start;
      first_reg = AW'(first);
      last_reg  = AW'(last);
      step();
      start = 1'b0;
      abort = 1'b0;
      check("start_busy", busy, 1);
      check("start_rd_addr", rd_addr, first);
      check("start_no_valid", out_valid, 0);
      while (exp_idx.size() > 0 && iters < 400) begin
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (iters % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         stalled   = out_valid && !out_ready;
         hold_data = out_data;
         hold_idx  = out_index;
         hold_last = out_last;
         if (out_valid && out_ready) begin
            check("word_index", out_index, exp_idx[0]);
            check("word_data", out_data, exp_data[0]);
            check("word_last", out_last, exp_idx.size() == 1);
            void'(exp_idx.pop_front());
            void'(exp_data.pop_front());
         end
         step();
         iters++;
         if (iters == 1) check("first_valid_latency", out_valid, 1);
         if (stalled) begin
            check("stall_data", out_data, hold_data);
            check("stall_index", out_index, hold_idx);
            check("stall_last", out_last, hold_last);
            check("stall_valid", out_valid, 1);
         end
         if (busy) check("rd_addr_in_range", (rd_addr >= first) && (rd_addr <= last), 1);
         if (done) done_seen++;
      end
      check("dump_words_left", exp_idx.size(), 0);
      check("done_pulse", done, 1);
      check("done_busy_low", busy, 0);
      check("done_valid_low", out_valid, 0);
      check("done_once", done_seen, 1);
      if (mode == 0) check("throughput_cycles", iters, n + 1);
      step();
      check("done_drops", done, 0);
   endtask

   initial begin
      int f;
      int l;
      reset     = 1'b1;
      start     = 1'b0;
      abort     = 1'b0;
      out_ready = 1'b0;
      first_reg = '0;
      last_reg  = '0;
      for (int r = 0; r < 32; r++) regs[r] = $urandom;
      regs[0]  = 32'h0000_0000;
      regs[5]  = 32'h0000_0011;
      regs[6]  = 32'h0000_0022;
      regs[7]  = 32'h0000_0033;
      regs[8]  = 32'h0000_0044;
      regs[31] = 32'hDEAD_BEEF;

      step();
      step();
      check("rst_busy", busy, 0);
      check("rst_valid", out_valid, 0);
      check("rst_done", done, 0);
      check("rst_range_err", range_err, 0);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_index", out_index, 0);
      check("rst_out_last", out_last, 0);
      reset = 1'b0;
      step();

      abort = 1'b1;
      step();
      abort = 1'b0;
      check("idle_abort_ignored", busy, 0);

      run_dump(5, 8, 0, 1'b0);
      run_dump(5, 8, 1, 1'b0);
      run_dump(31, 31, 0, 1'b0);
      run_dump(0, 31, 0, 1'b0);

      start     = 1'b1;
      first_reg = 5'd9;
      last_reg  = 5'd3;
      step();
      start = 1'b0;
      check("range_err_pulse", range_err, 1);
      check("range_err_busy", busy, 0);
      check("range_err_valid", out_valid, 0);
      step();
      check("range_err_drops", range_err, 0);
      check("range_err_still_idle", busy, 0);

      for (int k = 0; k < 6; k++) begin
         f = $urandom_range(0, 31);
         l = $urandom_range(f, 31);
         run_dump(f, l, 2, 1'($urandom_range(0, 1)));
      end

      out_ready = 1'b1;
      start     = 1'b1;
      first_reg = 5'd0;
      last_reg  = 5'd31;
      step();
      start = 1'b0;
      step();
      check("abort_w0_index", out_index, 0);
      check("abort_w0_data", out_data, 0);
      step();
      check("abort_w1_index", out_index, 1);
      step();
      check("abort_w2_index", out_index, 2);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_valid", out_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_no_done", done, 0);
      step();
      check("abort_no_done_later", done, 0);
      check("abort_idle", busy, 0);

      start     = 1'b1;
      first_reg = 5'd4;
      last_reg  = 5'd20;
      step();
      start = 1'b0;
      step();
      step();
      check("pre_reset_busy", busy, 1);
      check("pre_reset_valid", out_valid, 1);
      reset = 1'b1;
      #1;
      check("async_rst_busy", busy, 0);
      check("async_rst_valid", out_valid, 0);
      check("async_rst_data", out_data, 0);
      check("async_rst_index", out_index, 0);
      check("async_rst_rd_addr", rd_addr, 0);
      check("async_rst_done", done, 0);
      check("async_rst_last", out_last, 0);
      step();
      reset = 1'b0;
      step();
      check("post_rst_no_done", done, 0);
      check("post_rst_idle", busy, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
